// File: rtl/gpi_debounce.sv
// Per-bit synchronise-and-debounce for GPI pins.
// Every accepted change to the debounced vector is also offered as a single-entry event stream.
module gpi_debounce #(
    parameter int DW              = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [DW-1:0] gpi_raw,
    output logic [DW-1:0] gpi_clean,
    output logic [DW-1:0] out_tdata,
    output logic          out_tvalid,
    input  logic          out_tready,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] sync1;
    logic [DW-1:0] sync2;
    logic [CW-1:0] cnt      [DW];
    logic [CW-1:0] cnt_next [DW];
    logic [DW-1:0] clean_next;
    logic          change;

    // A bit's counter runs only while its synchronised level disagrees with the clean level.
    always_comb begin
        clean_next = gpi_clean;
        for (int i = 0; i < DW; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != gpi_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    assign change = (clean_next != gpi_clean);

    // Handshake: an event transfers on an edge where out_tvalid and out_tready are both 1.
    // out_tvalid is a register, never a function of out_tready; a new change always wins over
    // the transfer, and overwriting an event nobody accepted raises the sticky ovf flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync1      <= '0;
            sync2      <= '0;
            gpi_clean  <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            ovf        <= 1'b0;
            for (int i = 0; i < DW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= gpi_raw;
            sync2     <= sync1;
            gpi_clean <= clean_next;
            for (int i = 0; i < DW; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (change) begin
                out_tvalid <= 1'b1;
                out_tdata  <= clean_next;
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end
            if (change && out_tvalid && !out_tready) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce (DW=8, DEBOUNCE_CYCLES=4).
// Stimulus pushes expected events; a negedge monitor pops them as the DUT presents each one.
module tb_gpi_debounce;

    localparam int W = 8;

    logic         aclk;
    logic         areset;
    logic [W-1:0] gpi_raw;
    logic [W-1:0] gpi_clean;
    logic [W-1:0] out_tdata;
    logic         out_tvalid;
    logic         out_tready;
    logic         ovf;
    logic         ovf_clr;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;

    gpi_debounce #(.DW(W), .DEBOUNCE_CYCLES(4)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .gpi_raw    (gpi_raw),
        .gpi_clean  (gpi_clean),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // driver tasks
    task automatic accept();
        out_tready = 1'b1;
        tick(1);
        out_tready = 1'b0;
    endtask

    task automatic debounce_to(input logic [W-1:0] v);
        gpi_raw = v;
        exp_q.push_back(v);
        tick(6);
    endtask

    // scoreboard monitor: a new event is a rising out_tvalid or new data while valid
    initial begin
        logic         prev_valid;
        logic [W-1:0] prev_data;
        logic [W-1:0] exp_v;
        prev_valid = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge aclk);
            if (!areset && out_tvalid && (!prev_valid || out_tdata != prev_data)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL event_unexpected: got %0h, expected no event", out_tdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("event_data", {24'd0, out_tdata}, {24'd0, exp_v});
                end
            end
            prev_valid = out_tvalid;
            prev_data  = out_tdata;
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        areset     = 1'b1;
        gpi_raw    = 8'hFF;
        out_tready = 1'b0;
        ovf_clr    = 1'b0;

        // reset startup
        #2;
        check("rst_clean", {24'd0, gpi_clean}, 32'h0);
        check("rst_tdata", {24'd0, out_tdata}, 32'h0);
        check("rst_tvalid", {31'd0, out_tvalid}, 32'h0);
        check("rst_ovf", {31'd0, ovf}, 32'h0);
        @(negedge aclk);
        areset = 1'b0;
        exp_q.push_back(8'hFF);
        tick(5);
        check("startup_clean_e5", {24'd0, gpi_clean}, 32'h00);
        tick(1);
        check("startup_clean_e6", {24'd0, gpi_clean}, 32'hFF);
        check("startup_tvalid", {31'd0, out_tvalid}, 32'h1);
        check("startup_tdata", {24'd0, out_tdata}, 32'hFF);
        accept();
        check("startup_accept", {31'd0, out_tvalid}, 32'h0);

        // glitch rejection
        debounce_to(8'h00);
        accept();
        gpi_raw = 8'h01;
        tick(3);
        gpi_raw = 8'h00;
        tick(10);
        check("glitch_clean", {24'd0, gpi_clean}, 32'h00);
        check("glitch_tvalid", {31'd0, out_tvalid}, 32'h0);

        // overflow and ovf_clr
        debounce_to(8'h01);
        check("ovf_first_clean", {24'd0, gpi_clean}, 32'h01);
        check("ovf_not_yet", {31'd0, ovf}, 32'h0);
        debounce_to(8'h03);
        check("ovf_tdata", {24'd0, out_tdata}, 32'h03);
        check("ovf_tvalid", {31'd0, out_tvalid}, 32'h1);
        check("ovf_set", {31'd0, ovf}, 32'h1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'h0);
        check("ovf_clr_tvalid", {31'd0, out_tvalid}, 32'h1);
        accept();

        // simultaneous accept and change
        debounce_to(8'h01);
        check("sim_pre_tdata", {24'd0, out_tdata}, 32'h01);
        gpi_raw = 8'h81;
        exp_q.push_back(8'h81);
        tick(5);
        out_tready = 1'b1;
        tick(1);
        out_tready = 1'b0;
        check("sim_tvalid", {31'd0, out_tvalid}, 32'h1);
        check("sim_tdata", {24'd0, out_tdata}, 32'h81);
        check("sim_ovf", {31'd0, ovf}, 32'h0);

        // reset mid-count (0x81 event left pending)
        gpi_raw = 8'h10;
        tick(4);
        #2;
        areset = 1'b1;
        #1;
        check("midrst_clean", {24'd0, gpi_clean}, 32'h00);
        check("midrst_tdata", {24'd0, out_tdata}, 32'h00);
        check("midrst_tvalid", {31'd0, out_tvalid}, 32'h0);
        tick(1);
        areset = 1'b0;
        exp_q.push_back(8'h10);
        tick(5);
        check("midrst_clean_e5", {24'd0, gpi_clean}, 32'h00);
        tick(1);
        check("midrst_clean_e6", {24'd0, gpi_clean}, 32'h10);
        accept();
        check("midrst_accept", {31'd0, out_tvalid}, 32'h0);

        // multi-bit change in one step
        debounce_to(8'h00);
        accept();
        debounce_to(8'hA5);
        check("multi_tdata", {24'd0, out_tdata}, 32'hA5);
        check("multi_tvalid", {31'd0, out_tvalid}, 32'h1);
        accept();
        check("multi_accept", {31'd0, out_tvalid}, 32'h0);
        check("multi_tdata_hold", {24'd0, out_tdata}, 32'hA5);

        tick(4);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter DW, default 8, giving the number of input bits.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the stable cycles required before a level is accepted; legal range is 1 or more.
REQ-004 The block SHALL have port aclk, input, 1 bit: the system clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: the asynchronous, active-high reset.
REQ-006 The block SHALL have port gpi_raw, input, DW bits: the unsynchronised button and switch pins.
REQ-007 The block SHALL have port gpi_clean, output, DW bits: the registered debounced level, which drives the gpi input of the downstream GPI stage.
REQ-008 The block SHALL have port out_tdata, output, DW bits: the change-event payload, equal to the new debounced vector.
REQ-009 The block SHALL have port out_tvalid, output, 1 bit: a change event is pending.
REQ-010 The block SHALL have port out_tready, input, 1 bit: the consumer accepts the pending event.
REQ-011 The block SHALL have port ovf, output, 1 bit: a sticky flag meaning an unaccepted event was overwritten.
REQ-012 The block SHALL have port ovf_clr, input, 1 bit: a synchronous clear for ovf.

Function
REQ-013 Each gpi_raw bit SHALL pass through a 2-flop synchroniser; the second flop output is called sync[i].
REQ-014 Each bit SHALL have an independent counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-015 When sync[i] equals gpi_clean[i], the counter for that bit SHALL be zero on the next edge.
REQ-016 When sync[i] differs from gpi_clean[i] and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-017 When sync[i] differs from gpi_clean[i] and the counter equals DEBOUNCE_CYCLES-1, gpi_clean[i] SHALL load sync[i] and the counter SHALL clear.
REQ-018 Latency: a raw level held stable SHALL appear on gpi_clean exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-019 A raw pulse or glitch shorter than DEBOUNCE_CYCLES cycles at sync[i] SHALL leave gpi_clean[i] and the event stream unchanged.
REQ-020 If one or more bits of gpi_clean change on an edge, the block SHALL, on the same edge, set out_tvalid to 1 and load out_tdata with the new gpi_clean value.
REQ-021 When several bits qualify on the same edge, the block SHALL emit a single event.
REQ-022 On an edge with out_tvalid=1, out_tready=1 and no change, the block SHALL clear out_tvalid; out_tdata SHALL keep its value.
REQ-023 On an edge with out_tvalid=1, out_tready=1 and a simultaneous change, out_tvalid SHALL remain 1 and out_tdata SHALL load the new value.
REQ-024 In the case of REQ-023, ovf SHALL NOT be set.
REQ-025 On an edge with out_tvalid=1, out_tready=0 and a change, out_tdata SHALL be overwritten with the latest value, out_tvalid SHALL remain 1 and ovf SHALL be set to 1.
REQ-026 While out_tvalid=1 and no change occurs, out_tdata SHALL be held stable regardless of out_tready.
REQ-027 When out_tvalid=0, out_tready SHALL be ignored.
REQ-028 When ovf_clr=1, ovf SHALL clear on the next edge.
REQ-029 When ovf_clr=1 and a new overflow occur on the same edge, the set SHALL win and ovf SHALL be 1.
REQ-030 out_tvalid SHALL NOT depend combinationally on out_tready.
REQ-031 gpi_clean, out_tdata, out_tvalid and ovf SHALL all be driven directly from registers.

Reset
REQ-032 While areset=1, asynchronously and without a clock edge, the block SHALL drive all synchroniser flops, counters, gpi_clean, out_tdata, out_tvalid and ovf to 0.
REQ-033 Asserting areset mid-count SHALL discard the partial count.
REQ-034 After reset release, any input bit held at 1 SHALL be debounced normally to 1 and SHALL produce one change event.

Verification (bench uses DW=8, DEBOUNCE_CYCLES=4)
REQ-035 Reset startup: areset=1 with gpi_raw=0xFF -> all outputs 0; release areset and hold gpi_raw=0xFF -> gpi_clean=0xFF exactly 6 edges after the first sampling edge, with one event out_tdata=0xFF and out_tvalid=1.
REQ-036 Glitch rejection: gpi_raw[0] high for 3 cycles, then low -> gpi_clean stays 0x00 and out_tvalid stays 0.
REQ-037 Overflow: out_tready=0; raw 0x01 is debounced, then raw 0x03 is debounced -> out_tdata=0x03, out_tvalid=1, ovf=1; then pulse ovf_clr for one cycle -> ovf=0 on the next edge, out_tvalid still 1.
REQ-038 Simultaneous accept and change: out_tvalid=1 with out_tdata=0x01; out_tready=1 on the same edge gpi_clean becomes 0x81 -> out_tvalid stays 1, out_tdata=0x81, ovf=0.
REQ-039 Reset mid-operation: gpi_raw=0x10 with bit 4's counter at 2, assert areset between clock edges -> outputs are 0 immediately; after release, gpi_clean reaches 0x10 a full 6 edges after the first sampling edge.
REQ-040 Multi-bit change: gpi_raw changes from 0x00 to 0xA5 in one step -> a single event out_tdata=0xA5; handshake with out_tready=1 -> out_tvalid=0 on the next edge.
